// File: rtl/regfile_sb.sv
// regfile_sb: register file with two bypassed read ports and a per-register busy scoreboard
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            flush,
  output logic [AW:0]     busy_cnt
);
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy, busy_nxt;
  logic [AW:0] cnt_nxt;
  logic wr_v, rsv_v, inc, dec, byp1, byp2;
  assign wr_v  = wr_en && wr_addr != '0;
  assign rsv_v = rsv_en && rsv_addr != '0 && !flush;
  assign byp1 = wr_v && wr_addr == rs1_addr;
  assign byp2 = wr_v && wr_addr == rs2_addr;
  assign rs1_data = byp1 ? wr_data : regs[rs1_addr];
  assign rs2_data = byp2 ? wr_data : regs[rs2_addr];
  assign rs1_busy = !byp1 && busy[rs1_addr];
  assign rs2_busy = !byp2 && busy[rs2_addr];
  // at most one bit can rise (reserve) and one fall (write), so the count moves by -1..+1
  assign inc = rsv_v && !busy[rsv_addr];
  assign dec = wr_v && busy[wr_addr] && !(rsv_v && rsv_addr == wr_addr);
  assign cnt_nxt = flush ? '0 : busy_cnt + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
  always_comb begin
    busy_nxt = busy;
    if (wr_v) busy_nxt[wr_addr] = 1'b0;
    if (rsv_v) busy_nxt[rsv_addr] = 1'b1;
    if (flush) busy_nxt = '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_v) regs[wr_addr] <= wr_data;
      busy <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks of regfile_sb at default and 64x16 parameters
module tb_regfile_sb;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [4:0] rs1_addr = '0, rs2_addr = '0, rsv_addr = '0, wr_addr = '0;
  logic [31:0] rs1_data, rs2_data, wr_data = '0;
  logic rs1_busy, rs2_busy, rsv_en = 1'b0, wr_en = 1'b0, flush = 1'b0;
  logic [5:0] busy_cnt;
  logic [3:0] b_rs1_addr = '0, b_rs2_addr = '0, b_rsv_addr = '0, b_wr_addr = '0;
  logic [63:0] b_rs1_data, b_rs2_data, b_wr_data = '0;
  logic b_rs1_busy, b_rs2_busy, b_rsv_en = 1'b0, b_wr_en = 1'b0;
  logic [4:0] b_busy_cnt;
  int errors = 0, checks = 0;

  regfile_sb dut (
    .clk(clk), .reset_n(reset_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .flush(flush), .busy_cnt(busy_cnt));

  regfile_sb #(.XLEN(64), .NREGS(16), .AW(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .rs1_addr(b_rs1_addr), .rs2_addr(b_rs2_addr),
    .rs1_data(b_rs1_data), .rs2_data(b_rs2_data), .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
    .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .flush(1'b0), .busy_cnt(b_busy_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) tick;
    reset_n = 1'b1;
    chk("reset_cnt", busy_cnt, 0);
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; rsv_en = 1; rsv_addr = 6;
    tick;
    wr_en = 0; rsv_en = 0; rs1_addr = 6; rs2_addr = 5;
    #1;
    chk("pre_rst_busy6", rs1_busy, 1);
    chk("pre_rst_r5", rs2_data, 32'hDEADBEEF);
    chk("pre_rst_cnt", busy_cnt, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("async_rst_r5", rs2_data, 0);
    chk("async_rst_busy6", rs1_busy, 0);
    chk("async_rst_cnt", busy_cnt, 0);
    #2 reset_n = 1'b1;
    tick;
    wr_en = 1; wr_addr = 3; wr_data = 32'h12345678; rs1_addr = 3; rs2_addr = 3;
    #1;
    chk("byp_rs1", rs1_data, 32'h12345678);
    chk("byp_rs2", rs2_data, 32'h12345678);
    chk("byp_busy1", rs1_busy, 0);
    chk("byp_busy2", rs2_busy, 0);
    tick;
    wr_en = 0;
    #1;
    chk("persist_rs1", rs1_data, 32'h12345678);
    chk("persist_rs2", rs2_data, 32'h12345678);
    rsv_en = 1; rsv_addr = 4; rs1_addr = 4;
    tick;
    rsv_en = 0;
    #1;
    chk("rsv4_busy", rs1_busy, 1);
    wr_en = 1; wr_addr = 4; wr_data = 32'h44;
    #1;
    chk("byp_busy_clr", rs1_busy, 0);
    chk("byp_data4", rs1_data, 32'h44);
    tick;
    wr_en = 0;
    #1;
    chk("wr4_cnt", busy_cnt, 0);
    wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; rsv_en = 1; rsv_addr = 0; rs1_addr = 0;
    #1;
    chk("x0_byp_data", rs1_data, 0);
    chk("x0_byp_busy", rs1_busy, 0);
    tick;
    wr_en = 0; rsv_en = 0;
    #1;
    chk("x0_data", rs1_data, 0);
    chk("x0_busy", rs1_busy, 0);
    chk("x0_cnt", busy_cnt, 0);
    rsv_en = 1;
    for (int r = 7; r <= 9; r++) begin
      rsv_addr = 5'(r);
      tick;
      chk($sformatf("rsv_cnt_r%0d", r), busy_cnt, 64'(r - 6));
    end
    rsv_en = 0; wr_en = 1; wr_addr = 8; wr_data = 32'h88;
    tick;
    wr_en = 0; rs1_addr = 8;
    #1;
    chk("wr8_busy", rs1_busy, 0);
    chk("wr8_cnt", busy_cnt, 2);
    rsv_en = 1; rsv_addr = 7; wr_en = 1; wr_addr = 7; wr_data = 32'h77;
    tick;
    rsv_en = 0; wr_en = 0; rs1_addr = 7;
    #1;
    chk("rw7_busy", rs1_busy, 1);
    chk("rw7_data", rs1_data, 32'h77);
    chk("rw7_cnt", busy_cnt, 2);
    rsv_en = 1; rsv_addr = 9;
    tick;
    rsv_en = 0;
    #1;
    chk("rerv9_cnt", busy_cnt, 2);
    flush = 1; rsv_en = 1; rsv_addr = 10; wr_en = 1; wr_addr = 9; wr_data = 32'hAA;
    tick;
    flush = 0; rsv_en = 0; wr_en = 0; rs1_addr = 10; rs2_addr = 9;
    #1;
    chk("flush_cnt", busy_cnt, 0);
    chk("flush_busy10", rs1_busy, 0);
    chk("flush_r9", rs2_data, 32'hAA);
    chk("flush_busy9", rs2_busy, 0);
    rs1_addr = 7;
    #1;
    chk("flush_busy7", rs1_busy, 0);
    b_rsv_en = 1;
    for (int r = 1; r < 16; r++) begin
      b_rsv_addr = 4'(r);
      tick;
    end
    b_rsv_addr = 0;
    tick;
    b_rsv_en = 0;
    #1;
    chk("b_full_cnt", b_busy_cnt, 15);
    b_rs1_addr = 15;
    #1;
    chk("b_busy15", b_rs1_busy, 1);
    b_wr_en = 1; b_wr_addr = 15; b_wr_data = 64'h0123456789ABCDEF;
    tick;
    b_wr_en = 0;
    #1;
    chk("b_r15", b_rs1_data, 64'h0123456789ABCDEF);
    chk("b_busy15_clr", b_rs1_busy, 0);
    chk("b_cnt14", b_busy_cnt, 14);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
